// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle between a requesting controller
// (master) and the bit-serial adder sequencer (slave).
// The sub field and its modport entries exist only when SERIAL_ADD_SUB_EN
// is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start, a, b, c_in, sub,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output busy, done, sum, c_out
    );
`else
    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. One full-adder slice is
// stepped through the operands LSB-first, one bit per clock, under a
// start/busy/done handshake. Latency WIDTH+1 clocks, one operation per
// WIDTH+2 clocks.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub select; when set
// on the accepting edge the block computes a - b as a + ~b + 1).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // One-bit full-adder cell, sum output.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // One-bit full-adder cell, carry output (majority).
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    logic             accept;
    logic             last_bit;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] load_b;
    logic             load_cy;

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (cnt == CNT_LAST);
    assign bit_s    = fa_sum(sa[0], sb[0], cy);
    assign bit_c    = fa_carry(sa[0], sb[0], cy);

    // Select the B operand and initial carry loaded on the accepting edge.
    always_comb begin
        load_b  = bus.b;
        load_cy = bus.c_in;
`ifdef SERIAL_ADD_SUB_EN
        if (bus.sub) begin
            load_b  = ~bus.b;
            load_cy = 1'b1;
        end
`endif
    end

    // Sequencer: IDLE -> RUN for WIDTH bits -> DONE for one cycle -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state <= RUN;
                RUN:     if (last_bit)  state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand load on accept, then one full-adder step per clock in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            cy      <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else if (accept) begin
            sa    <= bus.a;
            sb    <= load_b;
            cy    <= load_cy;
            cnt   <= '0;
            sum_q <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            cy    <= bit_c;
            cnt   <= cnt + CNT_W'(1);
            sum_q <= {bit_s, sum_q[WIDTH-1:1]};
            // The carry out of the top bit is the final carry.
            if (last_bit) c_out_q <= bit_c;
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl (WIDTH=8).
// Expected results are queued when an accept is modelled and compared when
// the modelled done cycle arrives; busy/done are compared every cycle.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [W:0] exp_q[$];
    logic [W:0] last_exp = '0;
    int         m_cnt    = 0;
    int         n_push   = 0;
    int         n_done   = 0;
    int         n_abort  = 0;
    logic       drv_sub  = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
    assign bus.sub = drv_sub;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the handshake timing and arithmetic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (exp_q.size() != 0) n_abort += exp_q.size();
            m_cnt = 0;
            exp_q.delete();
        end else if (m_cnt == 0) begin
            if (bus.start === 1'b1) begin
                logic [W-1:0] bb;
                logic [W:0]   t;
                bb = bus.b;
                t  = {1'b0, bus.a} + {1'b0, bb} + {{W{1'b0}}, bus.c_in};
`ifdef SERIAL_ADD_SUB_EN
                if (drv_sub) t = {1'b0, bus.a} + {1'b0, ~bb} + {{W{1'b0}}, 1'b1};
`endif
                exp_q.push_back(t);
                n_push++;
                m_cnt = 1;
            end
        end else begin
            m_cnt = (m_cnt == W + 1) ? 0 : m_cnt + 1;
        end
    end

    // Per-cycle comparison of busy/done and result check on done.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, (m_cnt != 0)});
            chk("done", {31'd0, bus.done}, {31'd0, (m_cnt == W + 1)});
            if (bus.done === 1'b1) n_done++;
            if (m_cnt == W + 1) begin
                if (exp_q.size() == 0) begin
                    chk("queue_empty_at_done", 32'd1, 32'd0);
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("sum",   {24'd0, bus.sum},   {24'd0, last_exp[W-1:0]});
                    chk("c_out", {31'd0, bus.c_out}, {31'd0, last_exp[W]});
                end
            end
        end
    end

    // Present one request once the model is idle; scrambles operands after.
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic is);
        int guard;
        guard = 0;
        while (m_cnt != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("idle_timeout", 32'd1, 32'd0);
        bus.a     = ia;
        bus.b     = ib;
        bus.c_in  = ic;
        drv_sub   = is;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.c_in  = 1'($urandom);
        drv_sub   = 1'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_cnt != 0 || exp_q.size() != 0) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        int dpos;
        int last_acc;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_done",  {31'd0, bus.done},  32'd0);
        chk("rst_sum",   {24'd0, bus.sum},   32'd0);
        chk("rst_c_out", {31'd0, bus.c_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed add with explicit latency/busy-length check.
        op(8'h5A, 8'h33, 1'b0, 1'b0);
        bc   = 0;
        dpos = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) bc++;
            if (bus.done === 1'b1) dpos = k;
        end
        chk("t1_busy_cycles", bc, 9);
        chk("t1_done_cycle", dpos, 9);
        chk("t1_sum", {24'd0, bus.sum}, 32'h8D);
        chk("t1_c_out", {31'd0, bus.c_out}, 32'd0);
        @(posedge clk); #1;

        op(8'hFF, 8'h01, 1'b0, 1'b0);
        op(8'h00, 8'h00, 1'b1, 1'b0);
        drain();
        chk("wrap_then_cin_sum", {24'd0, bus.sum}, 32'h01);

`ifdef SERIAL_ADD_SUB_EN
        op(8'h10, 8'h01, 1'b0, 1'b1);
        drain();
        chk("sub1_sum", {24'd0, bus.sum}, 32'h0F);
        chk("sub1_c_out", {31'd0, bus.c_out}, 32'd1);
        op(8'h01, 8'h02, 1'b1, 1'b1);
        drain();
        chk("sub2_sum", {24'd0, bus.sum}, 32'hFF);
        chk("sub2_c_out", {31'd0, bus.c_out}, 32'd0);
`endif

        // start held high; operands only valid while idle.
        last_acc = -1;
        for (int i = 0; i < 42; i++) begin
            bus.start = 1'b1;
            if (m_cnt == 0) begin
                bus.a    = 8'h01;
                bus.b    = 8'h01;
                bus.c_in = 1'b0;
                drv_sub  = 1'b0;
            end else begin
                bus.a    = W'($urandom);
                bus.b    = W'($urandom);
                bus.c_in = 1'($urandom);
                drv_sub  = 1'($urandom);
            end
            @(posedge clk); #1;
            if (m_cnt == 1) begin
                if (last_acc >= 0) chk("tput_gap", i - last_acc, W + 2);
                last_acc = i;
            end
        end
        bus.start = 1'b0;
        drain();
        chk("tput_sum", {24'd0, bus.sum}, 32'h02);

        // Reset in the middle of RUN aborts without a done pulse.
        op(8'hA5, 8'h5A, 1'b1, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, bus.busy},  32'd0);
        chk("abort_done",  {31'd0, bus.done},  32'd0);
        chk("abort_sum",   {24'd0, bus.sum},   32'd0);
        chk("abort_c_out", {31'd0, bus.c_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (12) begin @(posedge clk); #1; end
        op(8'h12, 8'h34, 1'b1, 1'b0);
        drain();
        chk("post_abort_sum", {24'd0, bus.sum}, 32'h47);

        // Back-to-back random sweep.
        for (int n = 0; n < 200; n++) begin
            op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end
        drain();

        // Result holds through idle.
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_sum",   {24'd0, bus.sum},   {24'd0, last_exp[W-1:0]});
        chk("hold_c_out", {31'd0, bus.c_out}, {31'd0, last_exp[W]});
        chk("done_count", n_done, n_push - n_abort);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
